// File: rtl/video_pixel_centroid_tracker_if.sv
// Bus bundle for the centroid tracker: the DMA pixel-sink port and the
// 4-word control port. The DUT takes the slave modport.
interface video_pixel_centroid_tracker_if;
   logic [31:0] pixel_slave_address;
   logic        pixel_slave_write;
   logic [15:0] pixel_slave_writedata;
   logic        pixel_slave_waitrequest;
   logic [1:0]  control_slave_address;
   logic        control_slave_chipselect;
   logic        control_slave_write_n;
   logic [31:0] control_slave_writedata;
   logic [31:0] control_slave_readdata;

   modport master (
      output pixel_slave_address, pixel_slave_write, pixel_slave_writedata,
      output control_slave_address, control_slave_chipselect,
      output control_slave_write_n, control_slave_writedata,
      input  pixel_slave_waitrequest, control_slave_readdata
   );

   modport slave (
      input  pixel_slave_address, pixel_slave_write, pixel_slave_writedata,
      input  control_slave_address, control_slave_chipselect,
      input  control_slave_write_n, control_slave_writedata,
      output pixel_slave_waitrequest, control_slave_readdata
   );
endinterface

// File: rtl/video_pixel_centroid_tracker.sv
// Thresholds an RGB565 pixel stream and reports the centroid of bright pixels per frame.
// Define CENTROID_IRQ_EN to add the frame-done interrupt output and its control bits.
module video_pixel_centroid_tracker #(
   parameter int          FRAME_WIDTH  = 320,
   parameter int          FRAME_HEIGHT = 240,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
   input  logic sys_clk_clk,
   input  logic sys_reset_reset_n,
`ifdef CENTROID_IRQ_EN
   output logic irq,
`endif
   video_pixel_centroid_tracker_if.slave bus
);
   localparam logic [1:0]  ACCUM  = 2'd0;
   localparam logic [1:0]  DIV    = 2'd1;
   localparam logic [1:0]  DONE   = 2'd2;
   localparam logic [15:0] LAST_X = 16'(FRAME_WIDTH - 1);
   localparam logic [15:0] LAST_Y = 16'(FRAME_HEIGHT - 1);

   logic [1:0]  state_reg;
   logic [15:0] x_reg, y_reg;
   logic [16:0] count_reg;
   logic [31:0] sum_x_reg, sum_y_reg;
   logic [4:0]  div_cnt_reg;
   logic [7:0]  threshold_reg;
   logic        enable_reg;
   logic        irq_en_reg, irq_pending_reg;
   logic [15:0] centroid_x_reg, centroid_y_reg;
   logic [16:0] pixel_count_reg;
   logic        hit_reg;
   logic [15:0] frame_counter_reg;
   logic [7:0]  resync_count_reg;

   logic        accept, resync, pix_hit, last_pixel, div_start, ctrl_wr;
   logic [7:0]  luma;
   logic [15:0] cur_x, cur_y;
   logic [16:0] count_new;
   logic [31:0] sum_x_new, sum_y_new;
   logic [1:0][31:0] dividend;
   logic [1:0][31:0] quotient;
   logic [31:0] readdata;

   assign accept    = bus.pixel_slave_write && (state_reg == ACCUM);
   assign ctrl_wr   = bus.control_slave_chipselect && !bus.control_slave_write_n;
   assign div_start = accept && enable_reg && last_pixel && (count_new != 17'd0);

   always_comb begin
      luma = {2'b00, bus.pixel_slave_writedata[15:11], 1'b0}
           + {2'b00, bus.pixel_slave_writedata[10:5]}
           + {2'b00, bus.pixel_slave_writedata[4:0], 1'b0};
      pix_hit    = luma >= threshold_reg;
      resync     = bus.pixel_slave_address == BASE_ADDR;
      // A resync pixel becomes (0,0) of a fresh frame, so it starts from empty sums
      cur_x      = resync ? 16'd0 : x_reg;
      cur_y      = resync ? 16'd0 : y_reg;
      count_new  = (resync ? 17'd0 : count_reg) + {16'd0, pix_hit};
      sum_x_new  = (resync ? 32'd0 : sum_x_reg) + (pix_hit ? {16'd0, cur_x} : 32'd0);
      sum_y_new  = (resync ? 32'd0 : sum_y_reg) + (pix_hit ? {16'd0, cur_y} : 32'd0);
      last_pixel = (cur_x == LAST_X) && (cur_y == LAST_Y);
      dividend   = {sum_y_new, sum_x_new};
   end

   // Restoring dividers for x (gi=0) and y (gi=1); quotient shifts in from the dividend's LSB side
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gen_div
         logic [31:0] quo_reg;
         logic [31:0] rem_reg;
         logic [32:0] shifted;
         logic        q_bit;
         logic [32:0] diff;

         assign shifted = {rem_reg, quo_reg[31]};
         assign q_bit   = shifted >= {16'd0, count_reg};
         assign diff    = shifted - {16'd0, count_reg};

         always_ff @(posedge sys_clk_clk) begin
            if (!sys_reset_reset_n) begin
               quo_reg <= '0;
               rem_reg <= '0;
            end else if (div_start) begin
               quo_reg <= dividend[gi];
               rem_reg <= '0;
            end else if (state_reg == DIV) begin
               quo_reg <= {quo_reg[30:0], q_bit};
               rem_reg <= q_bit ? diff[31:0] : shifted[31:0];
            end
         end

         assign quotient[gi] = quo_reg;
      end
   endgenerate

   always_ff @(posedge sys_clk_clk) begin
      if (!sys_reset_reset_n) begin
         state_reg         <= ACCUM;
         x_reg             <= '0;
         y_reg             <= '0;
         count_reg         <= '0;
         sum_x_reg         <= '0;
         sum_y_reg         <= '0;
         div_cnt_reg       <= '0;
         centroid_x_reg    <= '0;
         centroid_y_reg    <= '0;
         pixel_count_reg   <= '0;
         hit_reg           <= 1'b0;
         frame_counter_reg <= '0;
         resync_count_reg  <= '0;
      end else begin
         case (state_reg)
            ACCUM: begin
               if (!enable_reg) begin
                  x_reg     <= '0;
                  y_reg     <= '0;
                  count_reg <= '0;
                  sum_x_reg <= '0;
                  sum_y_reg <= '0;
               end else if (accept) begin
                  count_reg <= count_new;
                  sum_x_reg <= sum_x_new;
                  sum_y_reg <= sum_y_new;
                  if (resync && resync_count_reg != 8'hFF)
                     resync_count_reg <= resync_count_reg + 8'd1;
                  if (last_pixel) begin
                     div_cnt_reg <= '0;
                     state_reg   <= (count_new != 17'd0) ? DIV : DONE;
                  end else if (cur_x == LAST_X) begin
                     x_reg <= '0;
                     y_reg <= cur_y + 16'd1;
                  end else begin
                     x_reg <= cur_x + 16'd1;
                     y_reg <= cur_y;
                  end
               end
            end
            DIV: begin
               div_cnt_reg <= div_cnt_reg + 5'd1;
               if (div_cnt_reg == 5'd31)
                  state_reg <= DONE;
            end
            DONE: begin
               // Quotients are stale when nothing was hit, so gate them with the count
               centroid_x_reg    <= (count_reg != 17'd0) ? quotient[0][15:0] : 16'd0;
               centroid_y_reg    <= (count_reg != 17'd0) ? quotient[1][15:0] : 16'd0;
               pixel_count_reg   <= count_reg;
               hit_reg           <= count_reg != 17'd0;
               frame_counter_reg <= frame_counter_reg + 16'd1;
               x_reg             <= '0;
               y_reg             <= '0;
               count_reg         <= '0;
               sum_x_reg         <= '0;
               sum_y_reg         <= '0;
               state_reg         <= ACCUM;
            end
            default: state_reg <= ACCUM;
         endcase
      end
   end

   always_ff @(posedge sys_clk_clk) begin
      if (!sys_reset_reset_n) begin
         threshold_reg <= 8'd96;
         enable_reg    <= 1'b1;
      end else if (ctrl_wr && bus.control_slave_address == 2'd0) begin
         threshold_reg <= bus.control_slave_writedata[7:0];
         enable_reg    <= bus.control_slave_writedata[8];
      end
   end

`ifdef CENTROID_IRQ_EN
   always_ff @(posedge sys_clk_clk) begin
      if (!sys_reset_reset_n) begin
         irq_en_reg      <= 1'b0;
         irq_pending_reg <= 1'b0;
      end else begin
         if (ctrl_wr && bus.control_slave_address == 2'd0)
            irq_en_reg <= bus.control_slave_writedata[9];
         if (state_reg == DONE)
            irq_pending_reg <= 1'b1;
         else if (ctrl_wr && bus.control_slave_address == 2'd3)
            irq_pending_reg <= 1'b0;
      end
   end
   assign irq = irq_pending_reg & irq_en_reg;
`else
   assign irq_en_reg      = 1'b0;
   assign irq_pending_reg = 1'b0;
`endif

   always_comb begin
      readdata = 32'd0;
      if (bus.control_slave_chipselect) begin
         case (bus.control_slave_address)
            2'd0: readdata = {22'd0, irq_en_reg, enable_reg, threshold_reg};
            2'd1: readdata = {centroid_y_reg, centroid_x_reg};
            2'd2: readdata = {15'd0, pixel_count_reg};
            default: readdata = {frame_counter_reg, resync_count_reg, 5'd0,
                                 irq_pending_reg, hit_reg, state_reg != ACCUM};
         endcase
      end
   end

   assign bus.control_slave_readdata  = readdata;
   assign bus.pixel_slave_waitrequest = state_reg != ACCUM;

   logic unused_bits;
   assign unused_bits = ^{bus.control_slave_writedata[31:9], quotient[0][31:16], quotient[1][31:16]};
endmodule

// File: tb/tb_video_pixel_centroid_tracker.sv
// Directed frames with a per-frame scoreboard of expected centroid results.
module tb_video_pixel_centroid_tracker;
   localparam int          W    = 128;
   localparam int          H    = 64;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam logic [31:0] NB   = 32'h0001_0000;
   localparam logic [15:0] P96  = {5'd16, 6'd32, 5'd16};
   localparam logic [15:0] P95  = {5'd16, 6'd31, 5'd16};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   video_pixel_centroid_tracker_if bus ();
`ifdef CENTROID_IRQ_EN
   logic irq;
`endif

   video_pixel_centroid_tracker #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .BASE_ADDR(BASE)) dut (
      .sys_clk_clk       (clk),
      .sys_reset_reset_n (rst_n),
`ifdef CENTROID_IRQ_EN
      .irq               (irq),
`endif
      .bus               (bus)
   );

   typedef struct {
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic        hit;
      logic [15:0] fc;
      logic [7:0]  rs;
      int          waits;
   } exp_t;

   exp_t        sbq[$];
   int          errors = 0;
   int          checks = 0;
   int          mx = 0, my = 0, mcnt = 0, msx = 0, msy = 0;
   int          mthr = 96;
   logic [15:0] mfc = 16'd0;
   logic [7:0]  mrs = 8'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int luma(input logic [15:0] p);
      return 2 * int'(p[15:11]) + int'(p[10:5]) + 2 * int'(p[4:0]);
   endfunction

   function automatic logic [15:0] pix(input int pat, input int x, input int y);
      case (pat)
         2: if ((x == 100 && y == 50) || (x == 102 && y == 60)) return 16'hFFFF;
         3: if (x == 5 && y == 0) return 16'hFFFF;
         4: if ((x == 10 && y == 20) || (x == 30 && y == 40)) return 16'hFFFF;
         5: begin
            if (x == W - 1 && y == H - 1) return 16'hFFFF;
            if (x == 10 && y == 10) return P96;
            if (x == 11 && y == 10) return P95;
         end
         6: if (x == 1 && y == 1) return 16'hFFFF;
         default: ;
      endcase
      return 16'h0000;
   endfunction

   task automatic model_accept(input logic [31:0] addr, input logic [15:0] data);
      exp_t e;
      if (addr == BASE) begin
         mx = 0; my = 0; mcnt = 0; msx = 0; msy = 0;
         if (mrs != 8'hFF) mrs = mrs + 8'd1;
      end
      if (luma(data) >= mthr) begin
         mcnt++; msx += mx; msy += my;
      end
      if (mx == W - 1 && my == H - 1) begin
         mfc     = mfc + 16'd1;
         e.fc    = mfc;
         e.rs    = mrs;
         e.hit   = mcnt != 0;
         e.reg2  = mcnt;
         e.reg1  = (mcnt != 0) ? {16'(msy / mcnt), 16'(msx / mcnt)} : 32'd0;
         e.waits = (mcnt != 0) ? 33 : 1;
         sbq.push_back(e);
         mx = 0; my = 0; mcnt = 0; msx = 0; msy = 0;
      end else if (mx == W - 1) begin
         mx = 0; my++;
      end else begin
         mx++;
      end
   endtask

   // Called just after a falling edge; returns one falling edge after the pixel is taken
   task automatic drive_px(input logic [31:0] addr, input logic [15:0] data);
      int n = 0;
      bus.pixel_slave_address   = addr;
      bus.pixel_slave_writedata = data;
      bus.pixel_slave_write     = 1'b1;
      #1;
      while (bus.pixel_slave_waitrequest && n < 100) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 100) check("px_accept_bound", 32'(n), 32'd0);
      model_accept(addr, data);
      @(negedge clk);
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus.control_slave_address    = a;
      bus.control_slave_write_n    = 1'b1;
      bus.control_slave_chipselect = 1'b1;
      #1;
      d = bus.control_slave_readdata;
      bus.control_slave_chipselect = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.control_slave_address    = a;
      bus.control_slave_writedata  = d;
      bus.control_slave_write_n    = 1'b0;
      bus.control_slave_chipselect = 1'b1;
      @(negedge clk);
      bus.control_slave_chipselect = 1'b0;
      bus.control_slave_write_n    = 1'b1;
   endtask

   task automatic run_pixels(input int pat, input int first, input int last);
      for (int i = first; i <= last; i++)
         drive_px(NB, pix(pat, i % W, i / W));
   endtask

   // Counts stall cycles after a frame, then pops the scoreboard and compares registers
   task automatic wait_done(input bit hold);
      int          n = 0;
      exp_t        e;
      logic [31:0] r1, r2, r3;
      if (hold) begin
         bus.pixel_slave_address   = NB;
         bus.pixel_slave_writedata = 16'hFFFF;
      end else begin
         bus.pixel_slave_write = 1'b0;
      end
      while (bus.pixel_slave_waitrequest === 1'b1 && n < 200) begin
         n++; @(negedge clk);
      end
      if (sbq.size() == 0) begin
         check("sb_underflow", 32'(sbq.size()), 32'd1);
      end else begin
         e = sbq.pop_front();
         rd(2'd1, r1); rd(2'd2, r2); rd(2'd3, r3);
         check("stall_cycles", 32'(n), 32'(e.waits));
         check("centroid", r1, e.reg1);
         check("pixel_count", r2, e.reg2);
         check("status", {8'd0, r3[31:8], r3[1:0]} >> 2, {8'd0, e.fc, e.rs} );
         check("hit_busy", {30'd0, r3[1:0]}, {30'd0, e.hit, 1'b0});
         $display("frame %0d: stall=%0d reg1=0x%08h reg2=%0d reg3=0x%08h", e.fc, n, r1, r2, r3);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      bus.pixel_slave_address      = NB;
      bus.pixel_slave_write        = 1'b0;
      bus.pixel_slave_writedata    = 16'h0000;
      bus.control_slave_address    = 2'd0;
      bus.control_slave_chipselect = 1'b0;
      bus.control_slave_write_n    = 1'b1;
      bus.control_slave_writedata  = 32'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      rd(2'd0, d); check("reset_reg0", d, 32'h0000_0160);
      rd(2'd1, d); check("reset_reg1", d, 32'h0);
      rd(2'd2, d); check("reset_reg2", d, 32'h0);
      rd(2'd3, d); check("reset_reg3", d, 32'h0);
      check("reset_waitrequest", {31'd0, bus.pixel_slave_waitrequest}, 32'd0);
`ifdef CENTROID_IRQ_EN
      check("reset_irq", {31'd0, irq}, 32'd0);
`endif

      wr(2'd0, 32'h0000_0360);
      rd(2'd0, d);
`ifdef CENTROID_IRQ_EN
      check("reg0_irq_en", d, 32'h0000_0360);
`else
      check("reg0_irq_en", d, 32'h0000_0160);
`endif
      $display("reset/config: reg0=0x%08h", d);

      // Frame 1: all black
      run_pixels(1, 0, W * H - 1);
      wait_done(1'b0);
`ifdef CENTROID_IRQ_EN
      check("irq_set", {31'd0, irq}, 32'd1);
      wr(2'd3, 32'd0);
      check("irq_cleared", {31'd0, irq}, 32'd0);
      rd(2'd3, d); check("irq_pending_cleared", {31'd0, d[2]}, 32'd0);
`endif

      // Frame 2: two bright pixels
      run_pixels(2, 0, W * H - 1);
      wait_done(1'b0);
      bus.control_slave_address = 2'd1;
      #1 check("readdata_no_cs", bus.control_slave_readdata, 32'd0);

      // Frame 3: resync after 1000 pixels, then the DMA holds a pixel across DIV/DONE
      run_pixels(3, 0, 999);
      drive_px(BASE, 16'h0000);
      run_pixels(4, 1, W * H - 1);
      wait_done(1'b1);

      // Frame 4: held pixel lands at (0,0), plus threshold-boundary pixels
      drive_px(NB, 16'hFFFF);
      run_pixels(5, 1, W * H - 1);
      wait_done(1'b0);

      // Frame 5: reset in the middle of the division
      run_pixels(6, 0, W * H - 1);
      bus.pixel_slave_write = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_div_busy", {31'd0, bus.pixel_slave_waitrequest}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_reset_waitrequest", {31'd0, bus.pixel_slave_waitrequest}, 32'd0);
`ifdef CENTROID_IRQ_EN
      check("post_reset_irq", {31'd0, irq}, 32'd0);
`endif
      rd(2'd0, d); check("post_reset_reg0", d, 32'h0000_0160);
      rd(2'd1, d); check("post_reset_reg1", d, 32'h0);
      rd(2'd3, d); check("post_reset_reg3", d, 32'h0);
      check("sb_pending_frame", 32'(sbq.size()), 32'd1);
      sbq.delete();
      $display("reset mid-division: reg3=0x%08h", d);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/video_pixel_centroid_tracker.md
Name: video_pixel_centroid_tracker

Overview:
- Avalon-MM write-sink that sits directly downstream of the video-in DMA master and consumes the RGB565 pixel stream it writes.
- Thresholds each pixel on an approximate luma value and accumulates hit count plus sum-of-x and sum-of-y over one frame.
- At frame end it divides the sums to produce the centroid of bright pixels, i.e. the hand position used by the theremin.
- Results and threshold are exposed on a 4-word control slave.

Parameters:
- FRAME_WIDTH, 320, pixels per line.
- FRAME_HEIGHT, 240, lines per frame.
- BASE_ADDR, 32'h0000_0000, pixel-sink address that marks pixel (0,0).

Ports:
- sys_clk_clk  in  1  system clock.
- sys_reset_reset_n  in  1  synchronous active-low reset.
- pixel_slave_address  in  32  DMA write address.
- pixel_slave_write  in  1  DMA write strobe.
- pixel_slave_writedata  in  16  RGB565 pixel.
- pixel_slave_waitrequest  out  1  stall to DMA master.
- control_slave_address  in  2  register select.
- control_slave_chipselect  in  1  register access enable.
- control_slave_write_n  in  1  active-low register write.
- control_slave_writedata  in  32  register write data.
- control_slave_readdata  out  32  register read data.

Behaviour:
- Reset: synchronous, active-low, sampled on sys_clk_clk rising edge; valid mid-operation.
  - Forces state ACCUM, zeroes all accumulators, x/y counters, results and frame counter.
  - Threshold returns to 8'd96; enable returns to 1.
  - pixel_slave_waitrequest=0, control_slave_readdata=0.
- Accepted pixel: pixel_slave_write=1 and waitrequest=0 in the same cycle.
- Luma: luma = {R,1'b0} + G + {B,1'b0}, 8-bit unsigned (max 187). Pixel is a hit when luma >= threshold.
- States:
  - ACCUM (waitrequest=0) → DIV on acceptance of the last pixel (x==FRAME_WIDTH-1, y==FRAME_HEIGHT-1) when hit count incl. that pixel > 0.
  - ACCUM → DONE instead when that count is 0.
  - DIV (waitrequest=1): two parallel 32-bit restoring dividers, sum_x/count and sum_y/count, 1 quotient bit per cycle, exactly 32 cycles → DONE.
  - DONE (waitrequest=1, 1 cycle): latch centroid, pixel count and hit flag; increment frame_counter (16-bit, wraps 0xFFFF→0); clear accumulators and x/y → ACCUM.
- Centroid values:
  - Count=0: centroid_x=centroid_y=0, hit flag=0.
  - Otherwise: quotient truncated to 16 bits, hit flag=1.
- Accumulator widths: count 17 bits; sum_x, sum_y 32 bits. No overflow at default geometry.
- Coordinates: x increments per accepted pixel; at FRAME_WIDTH-1 it wraps to 0 and y increments.
- Resync: an accepted pixel with address==BASE_ADDR is treated as (0,0). Accumulators restart with that pixel only; the partial frame is discarded; resync_count (8-bit, saturating at 255) increments.
- enable=0: pixels are still accepted (waitrequest=0) but ignored. Accumulators and x/y are held at 0; state stays ACCUM.
- Clearing enable during DIV: the division completes and its results are latched.
- Control write: chipselect=1 and write_n=0; takes effect next cycle. A threshold change mid-frame applies from the next accepted pixel.
- Control read: readdata is combinational from address whenever chipselect=1, else 0.
  - 0: RW {22'b0, irq_en, enable, threshold[7:0]}.
  - 1: RO {centroid_y[15:0], centroid_x[15:0]}.
  - 2: RO {15'b0, pixel_count[16:0]}.
  - 3: RO {frame_counter[15:0], resync_count[7:0], 5'b0, irq_pending, hit, busy}; busy=1 in DIV/DONE. Writes to address 3 clear irq_pending.
- Latched results hold until the next DONE.

Optional Feature:
- Macro: CENTROID_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit, reset 0), equal to irq_pending AND irq_en.
  - irq_pending is set in DONE and cleared by a reg-3 write. If set and clear happen in the same cycle, set wins.
- Undefined: no irq port; reg-0 bit 9 and reg-3 bit 2 read 0 and writes to them are ignored.

Test Plan:
- Reset, then read all regs → reg0=0x0000_0160, reg1=0, reg2=0, reg3=0, waitrequest=0.
- Full frame of 0x0000 pixels, threshold 96 → 1-cycle DONE, reg1=0, hit=0, frame_counter=1.
- Frame with only (100,50) and (102,60) = 0xFFFF → waitrequest high 33 cycles, reg1=0x0037_0065, reg2=2, hit=1.
- Mid-frame pixel write to BASE_ADDR after 1000 pixels → resync_count=1; next completed frame centroid reflects post-resync pixels only.
- Hold waitrequest during DIV while DMA keeps write=1 → pixel held, not counted twice; accepted on first cycle after DONE as (0,0).
- CENTROID_IRQ_EN, irq_en=1: frame completes → irq=1; write reg3 → irq=0 next cycle; reset mid-DIV → irq=0, state ACCUM.
